// File: rtl/m2_sram_writer.sv
// m2_sram_writer: reads one 8x8 block of S values, clips each to 8 bits and writes pixel pairs to SRAM.
// Rev 1.0
`default_nettype none

module m2_sram_writer #(
  parameter logic [17:0] Y_BASE           = 18'd0,
  parameter logic [17:0] U_BASE           = 18'd38400,
  parameter logic [17:0] V_BASE           = 18'd57600,
  parameter int          Y_WORDS_PER_ROW  = 160,
  parameter int          UV_WORDS_PER_ROW = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  segment,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [5:0]  S_RAM_address,
  input  logic [31:0] S_RAM_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LI_0 = 3'd1,
    LI_1 = 3'd2,
    CC_0 = 3'd3,
    CC_1 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  seg_q, seg_nxt;
  logic [4:0]  row_q, row_nxt;
  logic [5:0]  col_q, col_nxt;
  logic [5:0]  cc_q, cc_nxt;
  logic [7:0]  even_q, even_nxt;
  logic [5:0]  s_addr_nxt;
  logic [17:0] sram_addr_nxt;
  logic [15:0] wdata_nxt;
  logic        we_n_nxt, busy_nxt, done_nxt;

  logic [7:0]  clip_val;
  logic [7:0]  pix_row;
  logic [17:0] row_off_y, row_off_uv, seg_base, seg_row_off, word_addr;

  // Constant multiply expanded into a sum of shifted copies of the operand.
  function automatic logic [17:0] mul_const(input logic [17:0] a, input int k);
    logic [17:0] acc;
    acc = '0;
    for (int b = 0; b < 18; b++) begin
      if (k[b]) acc = acc + (a << b);
    end
    return acc;
  endfunction

  always_comb begin
    clip_val = S_RAM_read_data[7:0];
    if ($signed(S_RAM_read_data) < 32'sd0)
      clip_val = 8'h00;
    else if ($signed(S_RAM_read_data) > 32'sd255)
      clip_val = 8'hFF;
  end

  // Word k = cc_q[5:1]: image row offset cc_q[5:3], word column cc_q[2:1].
  assign pix_row    = {row_q, cc_q[5:3]};
  assign row_off_y  = mul_const({10'd0, pix_row}, Y_WORDS_PER_ROW);
  assign row_off_uv = mul_const({10'd0, pix_row}, UV_WORDS_PER_ROW);

  always_comb begin
    seg_base    = V_BASE;
    seg_row_off = row_off_uv;
    case (seg_q)
      2'd0: begin
        seg_base    = Y_BASE;
        seg_row_off = row_off_y;
      end
      2'd1: seg_base = U_BASE;
      default: seg_base = V_BASE;
    endcase
  end

  assign word_addr = seg_base + seg_row_off + {10'd0, col_q, 2'b00} + {16'd0, cc_q[2:1]};

  always_comb begin
    state_nxt     = state;
    seg_nxt       = seg_q;
    row_nxt       = row_q;
    col_nxt       = col_q;
    cc_nxt        = cc_q;
    even_nxt      = even_q;
    s_addr_nxt    = S_RAM_address;
    sram_addr_nxt = SRAM_address;
    wdata_nxt     = SRAM_write_data;
    we_n_nxt      = 1'b1;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          seg_nxt   = segment;
          row_nxt   = block_row;
          col_nxt   = block_col;
          cc_nxt    = 6'd0;
          busy_nxt  = 1'b1;
          state_nxt = LI_0;
        end
      end
      LI_0: begin
        s_addr_nxt = 6'd0;
        state_nxt  = LI_1;
      end
      LI_1: begin
        s_addr_nxt = 6'd1;
        state_nxt  = CC_0;
      end
      CC_0: begin
        even_nxt = clip_val;
        if (cc_q < 6'd62) s_addr_nxt = cc_q + 6'd2;
        cc_nxt    = cc_q + 6'd1;
        state_nxt = CC_1;
      end
      CC_1: begin
        wdata_nxt     = {even_q, clip_val};
        we_n_nxt      = 1'b0;
        sram_addr_nxt = word_addr;
        if (cc_q < 6'd62) s_addr_nxt = cc_q + 6'd2;
        cc_nxt    = cc_q + 6'd1;
        state_nxt = (cc_q == 6'd63) ? DONE : CC_0;
      end
      DONE: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      seg_q           <= 2'd0;
      row_q           <= 5'd0;
      col_q           <= 6'd0;
      cc_q            <= 6'd0;
      even_q          <= 8'd0;
      S_RAM_address   <= 6'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      seg_q           <= seg_nxt;
      row_q           <= row_nxt;
      col_q           <= col_nxt;
      cc_q            <= cc_nxt;
      even_q          <= even_nxt;
      S_RAM_address   <= s_addr_nxt;
      SRAM_address    <= sram_addr_nxt;
      SRAM_write_data <= wdata_nxt;
      SRAM_we_n       <= we_n_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m2_sram_writer.sv
// tb_m2_sram_writer: directed vector bench for m2_sram_writer with an S RAM model and write monitor.
`default_nettype none

module tb_m2_sram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  segment;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [5:0]  S_RAM_address;
  logic [31:0] S_RAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        busy;
  logic        done;

  m2_sram_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .segment         (segment),
    .block_row       (block_row),
    .block_col       (block_col),
    .S_RAM_address   (S_RAM_address),
    .S_RAM_read_data (S_RAM_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // S RAM with one-clock registered read
  logic [31:0] s_mem [64];
  always @(posedge clk) S_RAM_read_data <= s_mem[S_RAM_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          w_edge [$];
  logic [17:0] w_a [$];
  logic [15:0] w_d [$];
  always @(negedge clk) begin
    if (reset && !SRAM_we_n) begin
      w_edge.push_back(cyc);
      w_a.push_back(SRAM_address);
      w_d.push_back(SRAM_write_data);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] clip8(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return u[7:0];
  endfunction

  function automatic logic [17:0] exp_addr(input logic [1:0] seg, input int row, input int col, input int k);
    int base, wpr, a;
    base = (seg == 2'd0) ? 0 : (seg == 2'd1) ? 38400 : 57600;
    wpr  = (seg == 2'd0) ? 160 : 80;
    a    = base + (row * 8 + k / 4) * wpr + col * 4 + k % 4;
    return 18'(a);
  endfunction

  task automatic load_pat(input int pat);
    for (int i = 0; i < 64; i++) s_mem[i] = i;
    if (pat == 1) begin
      s_mem[0] = -5;
      s_mem[1] = 300;
      s_mem[2] = 255;
      s_mem[3] = 0;
      s_mem[4] = 32'h8000_0000;
      s_mem[5] = 32'h7FFF_FFFF;
    end
  endtask

  task automatic clear_mon();
    w_edge.delete();
    w_a.delete();
    w_d.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_addr"}, 32'(S_RAM_address), 0);
    chk({tag, "_sram_addr"}, 32'(SRAM_address), 0);
    chk({tag, "_wdata"}, 32'(SRAM_write_data), 0);
    chk({tag, "_we_n"}, 32'(SRAM_we_n), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Pulses start, optionally injects ignored starts at clocks 10 and 40, waits for done.
  task automatic run_block(input logic [1:0] seg, input logic [4:0] row, input logic [5:0] col,
                           input int extra, output int t0);
    int e;
    bit got;
    @(negedge clk);
    clear_mon();
    segment = seg; block_row = row; block_col = col;
    start = 1'b1;
    t0 = cyc + 1;
    e = -1; got = 0;
    while (!got && e < 200) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (e == 0) chk("busy_after_start", 32'(busy), 1);
      start = (extra != 0) && (e == 9 || e == 39);
      if (done) got = 1;
    end
    start = 1'b0;
    chk("start_to_done", 32'(e), 67);
    chk("busy_at_done", 32'(busy), 0);
  endtask

  task automatic verify_writes(input logic [1:0] seg, input logic [4:0] row, input logic [5:0] col, input int t0);
    chk("write_count", 32'(w_a.size()), 32);
    for (int k = 0; k < w_a.size() && k < 32; k++) begin
      chk($sformatf("addr_w%0d", k), 32'(w_a[k]), 32'(exp_addr(seg, row, col, k)));
      chk($sformatf("data_w%0d", k), 32'(w_d[k]), 32'({clip8(s_mem[2*k]), clip8(s_mem[2*k+1])}));
      chk($sformatf("edge_w%0d", k), 32'(w_edge[k] - t0), 32'(4 + 2 * k));
    end
  endtask

  typedef struct {
    logic [1:0]  seg;
    logic [4:0]  row;
    logic [5:0]  col;
    int          pat;
    logic [17:0] a_first, a_row1, a_last;
    logic [15:0] d0, d1, d2, d_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, e, e2;
    bit got;

    vecs[0] = '{2'd0, 5'd0,  6'd0,  0, 18'd0,     18'd160,   18'd1123,  16'h0001, 16'h0203, 16'h0405, 16'h3E3F};
    vecs[1] = '{2'd0, 5'd0,  6'd0,  1, 18'd0,     18'd160,   18'd1123,  16'h00FF, 16'hFF00, 16'h00FF, 16'h3E3F};
    vecs[2] = '{2'd1, 5'd29, 6'd19, 0, 18'd57036, 18'd57116, 18'd57599, 16'h0001, 16'h0203, 16'h0405, 16'h3E3F};
    vecs[3] = '{2'd2, 5'd1,  6'd2,  0, 18'd58248, 18'd58328, 18'd58811, 16'h0001, 16'h0203, 16'h0405, 16'h3E3F};
    vecs[4] = '{2'd3, 5'd1,  6'd2,  0, 18'd58248, 18'd58328, 18'd58811, 16'h0001, 16'h0203, 16'h0405, 16'h3E3F};
    vecs[5] = '{2'd0, 5'd29, 6'd39, 1, 18'd37276, 18'd37436, 18'd38399, 16'h00FF, 16'hFF00, 16'h00FF, 16'h3E3F};

    reset = 1'b1; start = 1'b0; segment = 2'd0; block_row = 5'd0; block_col = 6'd0;
    load_pat(0);
    #3 reset = 1'b0;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load_pat(vecs[i].pat);
      run_block(vecs[i].seg, vecs[i].row, vecs[i].col, 0, t0);
      verify_writes(vecs[i].seg, vecs[i].row, vecs[i].col, t0);
      if (w_a.size() == 32) begin
        chk($sformatf("v%0d_first_addr", i), 32'(w_a[0]),  32'(vecs[i].a_first));
        chk($sformatf("v%0d_row1_addr", i),  32'(w_a[4]),  32'(vecs[i].a_row1));
        chk($sformatf("v%0d_last_addr", i),  32'(w_a[31]), 32'(vecs[i].a_last));
        chk($sformatf("v%0d_word0", i),      32'(w_d[0]),  32'(vecs[i].d0));
        chk($sformatf("v%0d_word1", i),      32'(w_d[1]),  32'(vecs[i].d1));
        chk($sformatf("v%0d_word2", i),      32'(w_d[2]),  32'(vecs[i].d2));
        chk($sformatf("v%0d_word31", i),     32'(w_d[31]), 32'(vecs[i].d_last));
      end
    end

    // Starts at clocks 10 and 40 land while busy and must be ignored
    load_pat(0);
    run_block(2'd0, 5'd2, 6'd5, 1, t0);
    verify_writes(2'd0, 5'd2, 6'd5, t0);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart_busy", 32'(busy), 0);
    end
    chk("no_restart_writes", 32'(w_a.size()), 32);

    // Start held through DONE is taken in the following IDLE cycle
    @(negedge clk);
    clear_mon();
    segment = 2'd0; block_row = 5'd0; block_col = 6'd0;
    start = 1'b1;
    t0 = cyc + 1;
    e = -1;
    while (e < 66) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (e == 0) start = 1'b0;
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_done_pulse", 32'(done), 1);
    chk("hold_busy_in_done", 32'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_accept_busy", 32'(busy), 1);
    chk("hold_first_writes", 32'(w_a.size()), 32);
    start = 1'b0;
    clear_mon();
    t1 = t0 + 68;
    e2 = 0; got = 0;
    while (!got && e2 < 200) begin
      @(posedge clk); e2++;
      @(negedge clk);
      if (done) got = 1;
    end
    chk("hold_start_to_done", 32'(e2), 67);
    verify_writes(2'd0, 5'd0, 6'd0, t1);

    // Reset in the middle of a write pulse
    @(negedge clk);
    clear_mon();
    segment = 2'd1; block_row = 5'd3; block_col = 6'd7;
    start = 1'b1;
    e = -1;
    while (e < 20) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (e == 0) start = 1'b0;
    end
    chk("we_low_pre_reset", 32'(SRAM_we_n), 0);
    #2 reset = 1'b0;
    #1 check_reset_vals("run");
    @(negedge clk);
    reset = 1'b1;
    load_pat(1);
    run_block(2'd1, 5'd3, 6'd7, 0, t0);
    verify_writes(2'd1, 5'd3, 6'd7, t0);

    // Reset while idle, then a full block
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals("idle");
    @(negedge clk);
    reset = 1'b1;
    load_pat(0);
    run_block(2'd2, 5'd29, 6'd19, 0, t0);
    verify_writes(2'd2, 5'd29, 6'd19, t0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/m2_sram_writer.md
# m2_sram_writer

Write-back stage of the Milestone 2 IDCT path. Once the IDCT datapath has filled an embedded dual-port RAM with the 64 signed 32-bit S values of one 8x8 block, this block reads them back and clips each to 8 bits. It packs pixel pairs into 16-bit words and writes the 32 words to the external SRAM at the block's position in the Y, U or V output segment. It is the SRAM-writing counterpart of the coefficient fetcher: one block per start pulse, sole SRAM master while busy.

## Interface
Parameters:
- Y_BASE, 18'd0: SRAM word address of Y output segment
- U_BASE, 18'd38400: SRAM word address of U output segment
- V_BASE, 18'd57600: SRAM word address of V output segment
- Y_WORDS_PER_ROW, 160: words per Y image row (320 px)
- UV_WORDS_PER_ROW, 80: words per U/V image row (160 px)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- segment  in  2  0=Y, 1=U, 2=V; 3 treated as V; sampled with start
- block_row  in  5  block row 0..29; sampled with start
- block_col  in  6  block col 0..39 (Y) / 0..19 (U,V); sampled with start
- S_RAM_address  out  6  registered read address into S RAM (port a)
- S_RAM_read_data  in  32  signed S value; RAM has 1-clock registered read
- SRAM_address  out  18  SRAM word address
- SRAM_write_data  out  16  packed pixel pair
- SRAM_we_n  out  1  SRAM write enable, active low
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last write

## Operation
- Reset values: S_RAM_address 0, SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1, busy 0, done 0, state IDLE.
- FSM: IDLE -> LI_0 -> LI_1 -> CC_0/CC_1 alternating 32 times each (64 CC cycles) -> DONE -> IDLE.
- IDLE: on start=1, latch segment/block_row/block_col, clear counters, set busy, go LI_0. Otherwise hold.
- LI_0 and LI_1: drive S_RAM_address 0 and then 1 (priming the read pipeline).
- Each CC cycle samples one S value, in address order 0..63. The first 62 CC cycles also drive the next address, 2..63.
- CC_0: clip the sample into the even-pixel register and drive SRAM_we_n=1.
- CC_1: clip the sample as the odd pixel. Register the write in the same cycle: SRAM_write_data={even,odd}, SRAM_we_n=0, and SRAM_address as given below.
- Clip rule: S<0 gives 0; S>255 gives 255; otherwise S[7:0]. Full 32-bit signed compare.
- S RAM layout is row-major: index i gives r=i[5:3], pixel column i[2:0]. Word k (0..31) gives r=k[4:2], c=k[1:0].
- Word address: base(seg) + (block_row*8 + r)*WPR + block_col*4 + c. WPR is Y_WORDS_PER_ROW for Y and UV_WORDS_PER_ROW otherwise. Build the multiplies from shifts and adds; the result is 18 bits and wraps with no range check.
- DONE: drive SRAM_we_n=1, done=1 and busy=0, then go to IDLE.
- start while busy, or while in DONE, is ignored; start is accepted in the IDLE cycle that follows.
- An asserted reset in any state forces all reset values immediately. A partially written block is left as is.

## Timing
- Call the edge that samples start edge 0. busy is high after edge 0.
- S value i is sampled at edge 3+i, i.e. 2 clocks after its address is registered.
- Write k is driven after edge 4+2k. SRAM_we_n is low for exactly one cycle, then high for one cycle: 32 single-cycle pulses, the first after edge 4 and the last after edge 66.
- done is high, and busy low, for the single cycle after edge 67. Start-to-done is 67 clocks.
- SRAM_address and SRAM_write_data are stable throughout each SRAM_we_n low cycle.

## Test plan
- Reset mid-idle and mid-run: all outputs at reset values asynchronously (SRAM_we_n=1 within the reset-low cycle). The next start completes with 32 writes.
- Y block (0,0) with S[i]=i: writes addresses 0,1,2,3 with data 0x0001, 0x0203, 0x0405, 0x0607. Row 1 goes to addresses 160..163, and the last write is address 1123 with data 0x3E3F. done follows 67 clocks after start.
- Clipping, block (0,0) Y, S[0..3] = -5, 300, 255, 0: word 0 = 0x00FF, word 1 = 0xFF00.
  - Also S=0x8000_0000 clips to 0x00 and S=0x7FFF_FFFF clips to 0xFF.
- U block row 29, col 19: first address 57036, last address 57599. No write at or beyond 57600.
- V block row 1, col 2: first address 58248, last 58811. segment=3 produces the identical address sequence.
- Back-to-back: start pulsed at clocks 10 and 40 (while busy) is ignored. start held through DONE is accepted one cycle after DONE. The total write count equals 32 per accepted start.
